// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared state encodings and PC-select indices for the fetch sequencer
package fetch_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_STEP  = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  localparam int NB_SEL       = 3;
  localparam int SEL_BRANCH   = 0;
  localparam int SEL_JUMP_INM = 1;
  localparam int SEL_JUMP_RS  = 2;

  // States in which the cycle counter advances.
  function automatic logic is_counting(input state_e s);
    return (s == ST_RUN) || (s == ST_FLUSH) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/redirect_priority_enc.sv
// rtl/redirect_priority_enc.sv - decode flags + stall to one-hot PC source select and redirect flag
module redirect_priority_enc
  import fetch_sequencer_pkg::*;
(
  input  logic              i_enable,
  input  logic              i_stall,
  input  logic              i_halt,
  input  logic              i_jump_inm,
  input  logic              i_jump_rs,
  input  logic              i_branch,
  input  logic              i_branch_taken,
  output logic [NB_SEL-1:0] o_sel,
  output logic              o_redirect
);

  always_comb begin
    o_sel = '0;
    // Stall and halt both override any redirect; ID re-presents or the core stops.
    if (i_enable && !i_stall && !i_halt) begin
      if (i_jump_rs) begin
        o_sel[SEL_JUMP_RS] = 1'b1;
      end else if (i_jump_inm) begin
        o_sel[SEL_JUMP_INM] = 1'b1;
      end else if (i_branch && i_branch_taken) begin
        o_sel[SEL_BRANCH] = 1'b1;
      end
    end
    o_redirect = |o_sel;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch-stage control FSM: PC enable, PC source select, NOP squash, run/halt, cycle counter
// Optional single-step mode enabled by defining FETCH_SEQ_STEP_EN.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int NB_CNT   = 32,
  parameter int NB_STATE = 3
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_step,
  input  logic                i_stall,
  input  logic                i_dec_jump_inm,
  input  logic                i_dec_jump_rs,
  input  logic                i_dec_branch,
  input  logic                i_branch_taken,
  input  logic                i_dec_halt,
  output logic                o_pc_en,
  output logic                o_jump_inm,
  output logic                o_jump_rs,
  output logic                o_branch,
  output logic                o_nop_reg,
  output logic                o_halted,
  output logic [NB_STATE-1:0] o_state,
  output logic [NB_CNT-1:0]   o_cycle_count
);

  state_e              state_q, state_d;
  logic                nop_q, nop_d;
  logic                halted_q, halted_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic [NB_SEL-1:0]   sel;
  logic                redirect;
  logic                fetch_active;
  logic                pc_en;

`ifdef FETCH_SEQ_STEP_EN
  logic from_step_q, from_step_d;
  assign fetch_active = (state_q == ST_RUN) || (state_q == ST_STEP);
`else
  logic unused_step;
  assign unused_step  = i_step;
  assign fetch_active = (state_q == ST_RUN);
`endif

  redirect_priority_enc u_redirect_priority_enc (
    .i_enable       (fetch_active),
    .i_stall        (i_stall),
    .i_halt         (i_dec_halt),
    .i_jump_inm     (i_dec_jump_inm),
    .i_jump_rs      (i_dec_jump_rs),
    .i_branch       (i_dec_branch),
    .i_branch_taken (i_branch_taken),
    .o_sel          (sel),
    .o_redirect     (redirect)
  );

  always_comb begin
    state_d = state_q;
    pc_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_RUN;
`ifdef FETCH_SEQ_STEP_EN
        end else if (i_step) begin
          state_d = ST_STEP;
`endif
        end
      end
`ifdef FETCH_SEQ_STEP_EN
      ST_RUN, ST_STEP: begin
`else
      ST_RUN: begin
`endif
        pc_en = !i_stall;
        if (!i_stall) begin
          if (i_dec_halt) begin
            pc_en   = 1'b0;
            state_d = ST_HALT;
          end else if (redirect) begin
            state_d = ST_FLUSH;
          end else if (state_q == ST_STEP) begin
            state_d = ST_IDLE;
          end
        end
      end
      // ID holds the squashed wrong-path slot here, so decode flags are ignored.
      ST_FLUSH: begin
        pc_en = !i_stall;
        if (!i_stall) begin
`ifdef FETCH_SEQ_STEP_EN
          state_d = from_step_q ? ST_IDLE : ST_RUN;
`else
          state_d = ST_RUN;
`endif
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    if (i_reset) begin
      state_d = ST_IDLE;
    end

    nop_d    = (state_d == ST_FLUSH);
    halted_d = (state_d == ST_HALT);

    cnt_d = cnt_q;
    if (i_reset) begin
      cnt_d = '0;
    end else if (is_counting(state_q) && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef FETCH_SEQ_STEP_EN
  // Remembers that the current flush came from a single step, so it falls back to IDLE.
  always_comb begin
    from_step_d = from_step_q;
    if (i_reset || state_d != ST_FLUSH) begin
      from_step_d = 1'b0;
    end else if (state_q == ST_STEP) begin
      from_step_d = 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    from_step_q <= from_step_d;
  end
`endif

  always_ff @(posedge i_clock) begin
    state_q  <= state_d;
    nop_q    <= nop_d;
    halted_q <= halted_d;
    cnt_q    <= cnt_d;
  end

  assign o_pc_en       = pc_en;
  assign o_jump_inm    = sel[SEL_JUMP_INM];
  assign o_jump_rs     = sel[SEL_JUMP_RS];
  assign o_branch      = sel[SEL_BRANCH];
  assign o_nop_reg     = nop_q;
  assign o_halted      = halted_q;
  assign o_state       = NB_STATE'(state_q);
  assign o_cycle_count = cnt_q;

endmodule
